spinn_in_mapper_pl: RTL and testbench
=====================================

// Module: spinn_in_mapper_pl
// PURPOSE
//  Parametrised successor of the AER->SpiNNaker input mapper: converts AER events into SpiNNaker MC packets.
//  Adds routing-key prefix, optional 32-bit payload packets, configurable FIFO depth and timeout, and a FIFO level output.
//  Sits between the HPU AER input path and the SpiNNaker link driver (spinn_driver) packet interface.
// PARAMETERS
//  AER_WIDTH       32   width of iaer_data (1..32), zero-extended to 32-bit key
//  FIFO_DEPTH      4    packet FIFO entries, power of 2, >=2
//  TIMEOUT_CYCLES  128  cycles of ipkt_rdy low before link-timeout dump (1..65535)
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous active-high reset
//  enable         in   1          block enable; 0 => iaer_rdy low, no writes
//  dump_on        in   1          pulse: enter commanded dump
//  dump_off       in   1          pulse: leave commanded dump
//  tx_data_mask   in   32         AND mask on zero-extended event
//  key_prefix     in   32         OR'd into masked event to form key
//  pl_en          in   1          1 => emit payload packets
//  dump_mode      out  1          registered: commanded dump OR link timeout
//  fifo_level     out  clog2(FIFO_DEPTH+1)  entries held
//  iaer_data      in   AER_WIDTH  event address
//  iaer_payload   in   32         event payload (used when pl_en)
//  iaer_vld       in   1          event valid
//  iaer_rdy       out  1          event ready
//  ipkt_data      out  72         packet: [71:40] payload, [39:8] key, [7:1] ctrl, [0] parity
//  ipkt_vld       out  1          packet valid
//  ipkt_rdy       in   1          packet ready
// BEHAVIOUR
//  - Reset: cmd_dump=1, dump_mode=1, FIFO empty, fifo_level=0, ipkt_vld=0, timeout counter=TIMEOUT_CYCLES.
//  - Transfers on vld&rdy, both sides. ipkt_vld/ipkt_data depend only on registers, never on ipkt_rdy.
//  - key = ({zero-ext iaer_data} & tx_data_mask) | key_prefix, computed at acceptance.
//  - ctrl[7:1]: bit1 = payload flag (= pl_en at acceptance), bits 7:2 = 0; payload field = iaer_payload if pl_en, else 0.
//  - parity bit0 set so that bits [39:0] (pl_en=0) or [71:0] (pl_en=1) have odd parity.
//  - Command: dump_off clears cmd_dump, dump_on sets it; both in same cycle => dump_off wins.
//  - Timeout: counter reloads on ipkt_rdy=1, else decrements to 0 and holds; timeout flag = counter==0.
//  - dump_mode <= cmd_dump | timeout (one-cycle registered).
//  - Normal (dump_mode=0): iaer_rdy = enable & ~full; ipkt_vld = ~empty; event accepted in cycle N appears at head
//    with ipkt_vld=1 in cycle N+1 if FIFO was empty.
//  - Simultaneous write and read: level unchanged; full FIFO accepts only when head popped in the same cycle is not
//    required -- full => iaer_rdy=0 regardless of ipkt_rdy.
//  - Dump (dump_mode=1): iaer_rdy = enable; accepted events discarded; ipkt_vld=0; FIFO drained one entry per cycle
//    (discarded) until empty.
//  - FIFO: circular buffer, read/write pointers wrap at FIFO_DEPTH; full = level==FIFO_DEPTH, empty = level==0.
//  - enable=0 mid-operation: stop accepting; FIFO keeps draining to ipkt as normal.
//  - Reset mid-operation: all contents lost, reset values above in the next cycle.
// CONFIGURATION
//  SPINN_IN_MAPPER_DROP_CNT_EN defined: adds output drop_cnt[31:0], reset 0, +1 per event accepted in dump mode
//    or per entry drained by dump; saturates at 32'hFFFFFFFF.
//  Not defined: no drop_cnt port, no counter logic; all else identical.
// TESTING
//  1. Reset, dump_off pulse, ipkt_rdy=1, pl_en=0, mask=FFFFFFFF, prefix=0, event 32'h00000012
//     -> next cycle ipkt_vld=1, ipkt_data[39:8]=32'h12, [71:40]=0, bit0 gives odd parity over [39:0].
//  2. pl_en=1, prefix=32'hA0000000, mask=32'h0000FFFF, event 32'h12345678, payload 32'hDEADBEEF
//     -> key 32'hA0005678, bit1=1, [71:40]=DEADBEEF, odd parity over [71:0].
//  3. ipkt_rdy=0, 4 events (FIFO_DEPTH=4) -> fifo_level=4, iaer_rdy=0;
//     release ipkt_rdy -> packets out in order, one per cycle.
//  4. ipkt_rdy held 0 for TIMEOUT_CYCLES+2 with 3 entries -> dump_mode=1, FIFO drains to 0 in 3 cycles,
//     iaer_rdy=1, no ipkt_vld; with macro drop_cnt=3.
//  5. dump_on and dump_off same cycle while in dump -> cmd_dump=0; dump_mode=0 one cycle later (link ready).
//  6. Write and read same cycle at fifo_level=2 -> level stays 2, order preserved; rst asserted mid-burst -> level=0, dump_mode=1.

Source files
------------

// File: rtl/spinn_in_mapper_pl.sv
`default_nettype none
// ============================================================================
// Module      : spinn_in_mapper_pl
// Description : Converts AER events into SpiNNaker multicast packets.
//               Each accepted event becomes a 72-bit packet that is queued in
//               a small circular FIFO in front of the link driver:
//                 [71:40] payload, [39:8] routing key, [7:1] ctrl, [0] parity
//               key = (zero-extended event & tx_data_mask) | key_prefix.
//               ctrl bit1 flags a payload packet. Parity is odd over [39:0]
//               for plain packets and over [71:0] for payload packets.
//               The block enters dump mode on command or when the link has
//               not been ready for TIMEOUT_CYCLES cycles. In dump mode
//               incoming events are accepted and discarded and the FIFO is
//               flushed one entry per cycle.
//
// Parameters  : AER_WIDTH       event width (1..32)
//               FIFO_DEPTH      packet FIFO entries (power of 2, >= 2)
//               TIMEOUT_CYCLES  ipkt_rdy-low cycles before link dump (1..65535)
//
// Ports       : clk, rst                  clock, synchronous active-high reset
//               enable                    block enable for the event input
//               dump_on, dump_off         dump command pulses (dump_off wins)
//               tx_data_mask, key_prefix  key formation
//               pl_en                     emit payload packets
//               dump_mode                 registered dump status
//               fifo_level                entries held in the FIFO
//               iaer_data/payload/vld/rdy event input handshake
//               ipkt_data/vld/rdy         packet output handshake
//               drop_cnt                  (optional) discarded event count
//
// Options     : SPINN_IN_MAPPER_DROP_CNT_EN adds the drop_cnt output, a
//               saturating count of events/entries discarded by dump mode.
//
// Revision    : 1.0  initial release
// ============================================================================
module spinn_in_mapper_pl #(
    parameter int AER_WIDTH      = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              dump_on,
    input  logic                              dump_off,
    input  logic [31:0]                       tx_data_mask,
    input  logic [31:0]                       key_prefix,
    input  logic                              pl_en,
    output logic                              dump_mode,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    input  logic [AER_WIDTH-1:0]              iaer_data,
    input  logic [31:0]                       iaer_payload,
    input  logic                              iaer_vld,
    output logic                              iaer_rdy,
    output logic [71:0]                       ipkt_data,
    output logic                              ipkt_vld,
    input  logic                              ipkt_rdy
`ifdef SPINN_IN_MAPPER_DROP_CNT_EN
    ,
    output logic [31:0]                       drop_cnt
`endif
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [15:0]      c_TMO_RELOAD = 16'(TIMEOUT_CYCLES);
    localparam logic [LVL_W-1:0] c_FULL_LVL   = LVL_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              cmd_dump_q,  cmd_dump_d;
    logic              dump_mode_q, dump_mode_d;
    logic [15:0]       tmo_cnt_q,   tmo_cnt_d;
    logic [LVL_W-1:0]  level_q,     level_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [71:0]       mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Packet formation at acceptance time
    // ------------------------------------------------------------------
    logic [31:0] w_event_ext;
    logic [31:0] w_key;
    logic [31:0] w_payload;
    logic [6:0]  w_ctrl;
    logic        w_parity;
    logic [71:0] w_pkt;

    assign w_event_ext = 32'(iaer_data);
    assign w_key       = (w_event_ext & tx_data_mask) | key_prefix;
    assign w_payload   = pl_en ? iaer_payload : 32'h0;
    assign w_ctrl      = {6'b0, pl_en};
    // The payload field is zero for plain packets, so one reduction over
    // bits [71:1] yields odd parity over the correct span in both cases.
    assign w_parity    = ~(^{w_payload, w_key, w_ctrl});
    assign w_pkt       = {w_payload, w_key, w_ctrl, w_parity};

    // ------------------------------------------------------------------
    // Handshake and FIFO control
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_timeout;
    logic w_wr;
    logic w_drain;
    logic w_rd;

    assign w_full    = (level_q == c_FULL_LVL);
    assign w_empty   = (level_q == '0);
    assign w_timeout = (tmo_cnt_q == 16'd0);

    // Full blocks the input even if the head leaves this cycle; this keeps
    // iaer_rdy independent of ipkt_rdy.
    assign iaer_rdy  = dump_mode_q ? enable : (enable & ~w_full);
    assign ipkt_vld  = ~dump_mode_q & ~w_empty;
    assign ipkt_data = mem_q[rd_ptr_q];

    assign w_wr      = iaer_vld & iaer_rdy & ~dump_mode_q;
    assign w_drain   = dump_mode_q & ~w_empty;
    assign w_rd      = (ipkt_vld & ipkt_rdy) | w_drain;

    assign dump_mode  = dump_mode_q;
    assign fifo_level = level_q;

    always_comb begin
        cmd_dump_d = cmd_dump_q;
        if (dump_off) begin
            cmd_dump_d = 1'b0;
        end else if (dump_on) begin
            cmd_dump_d = 1'b1;
        end

        tmo_cnt_d = tmo_cnt_q;
        if (ipkt_rdy) begin
            tmo_cnt_d = c_TMO_RELOAD;
        end else if (!w_timeout) begin
            tmo_cnt_d = tmo_cnt_q - 16'd1;
        end

        dump_mode_d = cmd_dump_q | w_timeout;

        level_d = level_q;
        case ({w_wr, w_rd})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // FIFO_DEPTH is a power of 2, so pointers wrap naturally.
        wr_ptr_d = w_wr ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = w_rd ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_dump_q  <= 1'b1;
            dump_mode_q <= 1'b1;
            tmo_cnt_q   <= c_TMO_RELOAD;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            cmd_dump_q  <= cmd_dump_d;
            dump_mode_q <= dump_mode_d;
            tmo_cnt_q   <= tmo_cnt_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage carries no reset: an entry is only observable once written.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= w_pkt;
        end
    end

`ifdef SPINN_IN_MAPPER_DROP_CNT_EN
    // ------------------------------------------------------------------
    // Drop counter: an input event discarded and a FIFO entry flushed in
    // the same cycle both count.
    // ------------------------------------------------------------------
    logic        w_dump_acc;
    logic [1:0]  w_drop_inc;
    logic [32:0] w_drop_sum;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    assign w_dump_acc = iaer_vld & iaer_rdy & dump_mode_q;
    assign w_drop_inc = {1'b0, w_dump_acc} + {1'b0, w_drain};
    assign w_drop_sum = {1'b0, drop_cnt_q} + {31'b0, w_drop_inc};
    assign drop_cnt_d = w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
    assign drop_cnt   = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 32'h0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spinn_in_mapper_pl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spinn_in_mapper_pl
// Description : Scoreboard bench for spinn_in_mapper_pl. A queue-based
//               reference model predicts dump status, FIFO occupancy and
//               packet contents; the monitor pops expected packets whenever
//               the DUT hands one to the link.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spinn_in_mapper_pl;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int LVLW  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              dump_on;
    logic              dump_off;
    logic [31:0]       tx_data_mask;
    logic [31:0]       key_prefix;
    logic              pl_en;
    logic              dump_mode;
    logic [LVLW-1:0]   fifo_level;
    logic [AW-1:0]     iaer_data;
    logic [31:0]       iaer_payload;
    logic              iaer_vld;
    logic              iaer_rdy;
    logic [71:0]       ipkt_data;
    logic              ipkt_vld;
    logic              ipkt_rdy;
`ifdef SPINN_IN_MAPPER_DROP_CNT_EN
    logic [31:0]       drop_cnt;
`endif

    always #5 clk = ~clk;

    spinn_in_mapper_pl #(
        .AER_WIDTH      (AW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .dump_on      (dump_on),
        .dump_off     (dump_off),
        .tx_data_mask (tx_data_mask),
        .key_prefix   (key_prefix),
        .pl_en        (pl_en),
        .dump_mode    (dump_mode),
        .fifo_level   (fifo_level),
        .iaer_data    (iaer_data),
        .iaer_payload (iaer_payload),
        .iaer_vld     (iaer_vld),
        .iaer_rdy     (iaer_rdy),
        .ipkt_data    (ipkt_data),
        .ipkt_vld     (ipkt_vld),
        .ipkt_rdy     (ipkt_rdy)
`ifdef SPINN_IN_MAPPER_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected packet from first principles: count ones, pick parity bit so
    // the total is odd.
    function automatic logic [71:0] exp_pkt(input logic [31:0] ev, input logic [31:0] mask,
                                            input logic [31:0] prefix, input logic [31:0] payload,
                                            input logic pl);
        logic [31:0] key;
        logic [31:0] pay;
        int          ones;
        logic        par;
        key  = (ev & mask) | prefix;
        pay  = pl ? payload : 32'h0;
        ones = $countones(key) + $countones(pay) + (pl ? 1 : 0);
        par  = ((ones % 2) == 0);
        return {pay, key, 6'd0, pl, par};
    endfunction

    // ------------------------------------------------------------------
    // Reference model + scoreboard (evaluated mid-cycle, inputs stable)
    // ------------------------------------------------------------------
    logic [71:0] sb_q[$];
    bit          m_cmd  = 1'b1;
    bit          m_dump = 1'b1;
    int          m_cnt  = TMO;
    longint      m_drop = 0;

    always @(negedge clk) begin : monitor
        int          sz;
        bit          exp_rdy;
        bit          nxt_dump;
        logic [71:0] head;
        sz      = sb_q.size();
        exp_rdy = enable && (m_dump || (sz < DEPTH));

        chk("dump_mode",  72'(dump_mode),  72'(m_dump));
        chk("fifo_level", 72'(fifo_level), 72'(sz));
        chk("iaer_rdy",   72'(iaer_rdy),   72'(exp_rdy));
        chk("ipkt_vld",   72'(ipkt_vld),   72'(!m_dump && (sz > 0)));
`ifdef SPINN_IN_MAPPER_DROP_CNT_EN
        chk("drop_cnt",   72'(drop_cnt),   72'(m_drop));
`endif

        // Output transfer presented by the DUT
        if (ipkt_vld && ipkt_rdy) begin
            if (sb_q.size() == 0) begin
                chk("pkt_unexpected", 72'(ipkt_vld), 72'(0));
            end else begin
                head = sb_q.pop_front();
                chk("ipkt_data", ipkt_data, head);
            end
        end

        // Dump flush
        if (m_dump && (sz > 0) && (sb_q.size() > 0)) begin
            void'(sb_q.pop_front());
            m_drop++;
        end

        // Input acceptance
        if (iaer_vld && exp_rdy) begin
            if (m_dump) m_drop++;
            else sb_q.push_back(exp_pkt(32'(iaer_data), tx_data_mask, key_prefix, iaer_payload, pl_en));
        end
        if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;

        nxt_dump = m_cmd || (m_cnt == 0);
        if (dump_off)     m_cmd = 1'b0;
        else if (dump_on) m_cmd = 1'b1;
        if (ipkt_rdy)        m_cnt = TMO;
        else if (m_cnt > 0)  m_cnt = m_cnt - 1;
        m_dump = nxt_dump;

        if (rst) begin
            sb_q.delete();
            m_cmd  = 1'b1;
            m_dump = 1'b1;
            m_cnt  = TMO;
            m_drop = 0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_dump_off();
        dump_off = 1'b1;
        step();
        dump_off = 1'b0;
        step(2);
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b1;
        dump_on      = 1'b0;
        dump_off     = 1'b0;
        tx_data_mask = 32'hFFFF_FFFF;
        key_prefix   = 32'h0;
        pl_en        = 1'b0;
        iaer_data    = '0;
        iaer_payload = 32'h0;
        iaer_vld     = 1'b0;
        ipkt_rdy     = 1'b1;
        step(3);
        rst = 1'b0;
        step();
        chk("reset_dump_mode",  72'(dump_mode),  72'(1));
        chk("reset_fifo_level", 72'(fifo_level), 72'(0));
        chk("reset_ipkt_vld",   72'(ipkt_vld),   72'(0));

        // Plain packet
        pulse_dump_off();
        iaer_data = 32'h0000_0012;
        iaer_vld  = 1'b1;
        step();
        iaer_vld = 1'b0;
        chk("t1_vld", 72'(ipkt_vld), 72'(1));
        chk("t1_pkt", ipkt_data, 72'h00000000_00000012_01);

        // Payload packet with prefix and mask
        pl_en        = 1'b1;
        key_prefix   = 32'hA000_0000;
        tx_data_mask = 32'h0000_FFFF;
        iaer_data    = 32'h1234_5678;
        iaer_payload = 32'hDEAD_BEEF;
        iaer_vld     = 1'b1;
        step();
        iaer_vld = 1'b0;
        chk("t2_pkt", ipkt_data, 72'hDEADBEEF_A0005678_02);
        step(2);

        // Fill to full with link stalled, then release
        ipkt_rdy = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            iaer_data    = $urandom;
            iaer_payload = $urandom;
            iaer_vld     = 1'b1;
            step();
        end
        iaer_vld = 1'b0;
        chk("t3_level_full", 72'(fifo_level), 72'(DEPTH));
        chk("t3_rdy_full",   72'(iaer_rdy),   72'(0));
        ipkt_rdy = 1'b1;
        step(DEPTH + 2);

        // Link timeout with three queued entries
        pl_en    = 1'b0;
        ipkt_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iaer_data = $urandom;
            iaer_vld  = 1'b1;
            step();
        end
        iaer_vld = 1'b0;
        step(TMO + 2);
        chk("t4_dump_mode", 72'(dump_mode),  72'(1));
        chk("t4_drained",   72'(fifo_level), 72'(0));
        chk("t4_rdy",       72'(iaer_rdy),   72'(1));
        iaer_vld = 1'b1;
        step(2);
        iaer_vld = 1'b0;
        ipkt_rdy = 1'b1;
        step(3);

        // Commanded dump, then simultaneous on/off
        dump_on = 1'b1;
        step();
        dump_on = 1'b0;
        step(3);
        dump_on  = 1'b1;
        dump_off = 1'b1;
        step();
        dump_on  = 1'b0;
        dump_off = 1'b0;
        step(3);

        // Simultaneous write/read at level 2, then reset mid-burst
        ipkt_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iaer_data = $urandom;
            iaer_vld  = 1'b1;
            step();
        end
        ipkt_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iaer_data = $urandom;
            step();
        end
        chk("t6_level_hold", 72'(fifo_level), 72'(2));
        rst = 1'b1;
        step();
        rst      = 1'b0;
        iaer_vld = 1'b0;
        chk("t6_rst_level", 72'(fifo_level), 72'(0));
        chk("t6_rst_dump",  72'(dump_mode),  72'(1));
        pulse_dump_off();

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            enable       = ($urandom_range(0, 9) != 0);
            dump_on      = ($urandom_range(0, 99) == 0);
            dump_off     = ($urandom_range(0, 29) == 0);
            pl_en        = $urandom_range(0, 1) == 1;
            tx_data_mask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            key_prefix   = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
            iaer_data    = $urandom;
            iaer_payload = $urandom;
            iaer_vld     = ($urandom_range(0, 9) < 6);
            ipkt_rdy     = ($urandom_range(0, 9) < 7);
            step();
        end

        rst      = 1'b0;
        dump_on  = 1'b0;
        dump_off = 1'b0;
        iaer_vld = 1'b0;
        ipkt_rdy = 1'b1;
        step(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
